// File: rtl/joy_db15_pkg.sv
// Shared types and helpers for the DB15 joystick adapter emulation.
// Declarations only; no latency, no backpressure.
package joy_db15_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Button positions within each 12-bit player word.
    typedef enum int {
        BTN_RIGHT = 0,
        BTN_LEFT  = 1,
        BTN_DOWN  = 2,
        BTN_UP    = 3,
        BTN_A     = 4,
        BTN_B     = 5,
        BTN_C     = 6,
        BTN_D     = 7,
        BTN_E     = 8,
        BTN_F     = 9,
        BTN_START = 10,
        BTN_L     = 11
    } btn_e;

    function automatic int cnt_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_filter.sv
// Synchronizer plus glitch filter for one async host strobe; level_o resets high.
// Latency SYNC_STAGES+FILTER_LEN cycles from pin to level_o; no backpressure.
module joy_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o
);

    localparam int N = SYNC_STAGES + FILTER_LEN - 1;

    logic [N-1:0]          chain_q;
    logic [FILTER_LEN-1:0] win;
    logic                  level_q;
    logic                  level_d;

    // The last synchronizer stage doubles as the newest sample of the filter window.
    assign win = chain_q[N-1:SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        if (&win) begin
            level_d = 1'b1;
        end else if (~|win) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '1;
            level_q <= 1'b1;
        end else begin
            chain_q <= {chain_q[N-2:0], pin_i};
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter: answers host LOAD/CLK strobes and serializes two player words.
// Pin-to-joy_data latency SYNC_STAGES+FILTER_LEN+1 cycles; the host paces everything, no backpressure.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int BITS_PER_PLAYER = 12,
    parameter int FRAME_BITS      = 24,
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_LEN      = 2,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               joy_load,
    input  logic                               joy_clk,
    input  logic [15:0]                        joystick1,
    input  logic [15:0]                        joystick2,
    output logic                               joy_data,
    output logic                               host_active,
    output logic                               frame_strobe,
    output logic                               overrun,
    output logic [cnt_width(FRAME_BITS)-1:0]   bit_count
);

    localparam int CW = cnt_width(FRAME_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    logic load_f;
    logic clk_f;

    joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_load_filt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pin_i   (joy_load),
        .level_o (load_f)
    );

    joy_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pin_i   (joy_clk),
        .level_o (clk_f)
    );

    logic unused_hi_bits;
    assign unused_hi_bits = ^{joystick1[15:BITS_PER_PLAYER], joystick2[15:BITS_PER_PLAYER]};

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ovr_q, ovr_d;
    logic                  strobe_q, strobe_d;
    logic                  host_q, host_d;
    logic                  clk_f_q;
    logic                  clk_rise;
    logic                  expired;
    logic [FRAME_BITS-1:0] image;

    assign image    = {~joystick2[BITS_PER_PLAYER-1:0], ~joystick1[BITS_PER_PLAYER-1:0]};
    assign clk_rise = clk_f & ~clk_f_q;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        strobe_d = 1'b0;
        host_d   = host_q;
        tmo_d    = tmo_q;

        if (!load_f) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end
        expired = (tmo_d == TMO_MAX);

        // LOAD low wins over every other event, including a coincident clock edge.
        if (!load_f) begin
            state_d = ST_LOAD;
            sreg_d  = image;
            cnt_d   = '0;
            ovr_d   = 1'b0;
            host_d  = 1'b1;
        end else if (expired) begin
            state_d = ST_IDLE;
            sreg_d  = '1;
            host_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sreg_d = {1'b1, sreg_q[FRAME_BITS-1:1]};
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_d == CNT_FULL) begin
                            strobe_d = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '1;
            cnt_q    <= '0;
            tmo_q    <= '0;
            ovr_q    <= 1'b0;
            strobe_q <= 1'b0;
            host_q   <= 1'b0;
            clk_f_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
            strobe_q <= strobe_d;
            host_q   <= host_d;
            clk_f_q  <= clk_f;
        end
    end

    assign joy_data     = sreg_q[0];
    assign host_active  = host_q;
    assign frame_strobe = strobe_q;
    assign overrun      = ovr_q;
    assign bit_count    = cnt_q;

endmodule
